// File: rtl/mul_arbiter.sv
// mul_arbiter: two-requester front end for a shared, fixed-latency multiply
// datapath. Grants one requester per cycle, registers its operands onto
// mul_A/mul_B, and tags each grant so the datapath output can be steered
// back to the right requester LATENCY cycles later.
// Contention policy is round-robin by default; defining MUL_ARB_FIXED_PRIO_EN
// makes req0 always win.
module mul_arbiter #(
  parameter int NUM_ELEMENTS = 33,
  parameter int A_BIT_LEN    = 17,
  parameter int B_BIT_LEN    = 17,
  parameter int LATENCY      = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req0_valid,
  input  logic                              req1_valid,
  output logic                              req0_ready,
  output logic                              req1_ready,
  input  logic [NUM_ELEMENTS*A_BIT_LEN-1:0] req0_A,
  input  logic [NUM_ELEMENTS*A_BIT_LEN-1:0] req1_A,
  input  logic [NUM_ELEMENTS*B_BIT_LEN-1:0] req0_B,
  input  logic [NUM_ELEMENTS*B_BIT_LEN-1:0] req1_B,
  output logic [NUM_ELEMENTS*A_BIT_LEN-1:0] mul_A,
  output logic [NUM_ELEMENTS*B_BIT_LEN-1:0] mul_B,
  output logic                              rsp0_valid,
  output logic                              rsp1_valid,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              idle
);

  localparam int IW = $clog2(MAX_INFLIGHT+1);

  logic               can_grant;
  logic               pick1;
  logic               grant;
  logic [LATENCY-1:0] vld_pipe;
  logic [LATENCY-1:0] id_pipe;
  logic               rsp_any;

`ifndef MUL_ARB_FIXED_PRIO_EN
  // id of the most recent grant; reset to 1 so req0 wins first contention
  logic last_id;
`endif

  // credit check and requester selection; nothing is granted during reset
  always_comb begin
    can_grant = !reset && (inflight < IW'(MAX_INFLIGHT));
`ifdef MUL_ARB_FIXED_PRIO_EN
    pick1 = !req0_valid;
`else
    pick1 = req1_valid && (!req0_valid || !last_id);
`endif
    req0_ready = can_grant && req0_valid && !pick1;
    req1_ready = can_grant && req1_valid && pick1;
    grant      = req0_ready || req1_ready;
  end

  // the oldest slot of the tag pipe is the datapath column owner; masked in
  // reset so a pre-reset grant can never surface
  always_comb begin
    rsp_any    = vld_pipe[LATENCY-1];
    rsp0_valid = !reset && rsp_any && !id_pipe[LATENCY-1];
    rsp1_valid = !reset && rsp_any &&  id_pipe[LATENCY-1];
    idle       = (inflight == '0) && !grant;
  end

  // grant tag shift register: slot k holds the grant from k+1 cycles ago
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-2:0], grant};
      id_pipe  <= {id_pipe[LATENCY-2:0], req1_ready};
    end
  end

  // outstanding-grant counter; grant and response in one cycle cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({grant, rsp_any})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // operand registers feeding the datapath, held between grants
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_A <= '0;
      mul_B <= '0;
    end else if (req0_ready) begin
      mul_A <= req0_A;
      mul_B <= req0_B;
    end else if (req1_ready) begin
      mul_A <= req1_A;
      mul_B <= req1_B;
    end
  end

`ifndef MUL_ARB_FIXED_PRIO_EN
  // round-robin pointer moves only when something is granted
  always_ff @(posedge clk) begin
    if (reset)           last_id <= 1'b1;
    else if (req0_ready) last_id <= 1'b0;
    else if (req1_ready) last_id <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: a cycle model predicts grants; each grant pushes an
// expected response (due cycle, requester id) onto a scoreboard queue that
// is popped when the response is due. A second instance with MAX_INFLIGHT=2
// runs a directed credit-limit sequence against constant tables.
module tb_mul_arbiter;
  localparam int NE   = 33;
  localparam int AL   = 17;
  localparam int BL   = 17;
  localparam int LAT  = 4;
  localparam int MAXI = 4;
  localparam int AW   = NE*AL;
  localparam int BW   = NE*BL;
  localparam int IW   = $clog2(MAXI+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [BW-1:0] b0 = '0, b1 = '0;
  logic          rdy0, rdy1, rsp0, rsp1, idle;
  logic [AW-1:0] mul_A;
  logic [BW-1:0] mul_B;
  logic [IW-1:0] inflight;

  logic          reset2 = 1'b1;
  logic          d2_v0 = 1'b0;
  logic          d2_rdy0, d2_rdy1, d2_rsp0, d2_rsp1, d2_idle;
  logic [AW-1:0] d2_mul_A;
  logic [BW-1:0] d2_mul_B;
  logic [1:0]    d2_infl;

  always #5 clk = ~clk;

  mul_arbiter #(.NUM_ELEMENTS(NE), .A_BIT_LEN(AL), .B_BIT_LEN(BL),
                .LATENCY(LAT), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset(reset), .req0_valid(v0), .req1_valid(v1),
    .req0_ready(rdy0), .req1_ready(rdy1), .req0_A(a0), .req1_A(a1),
    .req0_B(b0), .req1_B(b1), .mul_A(mul_A), .mul_B(mul_B),
    .rsp0_valid(rsp0), .rsp1_valid(rsp1), .inflight(inflight), .idle(idle));

  mul_arbiter #(.NUM_ELEMENTS(NE), .A_BIT_LEN(AL), .B_BIT_LEN(BL),
                .LATENCY(4), .MAX_INFLIGHT(2)) dut2 (
    .clk(clk), .reset(reset2), .req0_valid(d2_v0), .req1_valid(1'b0),
    .req0_ready(d2_rdy0), .req1_ready(d2_rdy1), .req0_A(a0), .req1_A(a1),
    .req0_B(b0), .req1_B(b1), .mul_A(d2_mul_A), .mul_B(d2_mul_B),
    .rsp0_valid(d2_rsp0), .rsp1_valid(d2_rsp1), .inflight(d2_infl),
    .idle(d2_idle));

  typedef struct { int due; logic id; } ent_t;
  ent_t sb[$];

  int n_chk = 0, n_pass = 0, cyc = 0;
  int n_gr0 = 0, n_gr1 = 0, n_rs0 = 0, n_rs1 = 0;
  int m_infl = 0;
  logic m_last = 1'b1;
  logic m_known = 1'b0;
  logic [AW-1:0] m_A = '0;
  logic [BW-1:0] m_B = '0;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [AW-1:0] rnd_a();
    logic [AW-1:0] v = '0;
    for (int i = 0; i < AW; i += 32) v = {v[AW-33:0], $urandom()};
    return v;
  endfunction

  function automatic logic [BW-1:0] rnd_b();
    logic [BW-1:0] v = '0;
    for (int i = 0; i < BW; i += 32) v = {v[BW-33:0], $urandom()};
    return v;
  endfunction

  // one clock cycle: drive, check against the model, advance the model
  task automatic step(input logic rst_i, input logic s0, input logic s1,
                      input logic [AW-1:0] ia0, input logic [AW-1:0] ia1,
                      input logic [BW-1:0] ib0, input logic [BW-1:0] ib1);
    logic e_r0, e_r1, can, g0, g1, due;
    @(negedge clk);
    reset = rst_i; v0 = s0; v1 = s1; a0 = ia0; a1 = ia1; b0 = ib0; b1 = ib1;
    #1;
    due  = m_known && !rst_i && sb.size() > 0 && sb[0].due == cyc;
    e_r0 = due && !sb[0].id;
    e_r1 = due &&  sb[0].id;
    can  = !rst_i && m_known && m_infl < MAXI;
`ifdef MUL_ARB_FIXED_PRIO_EN
    g0 = can && s0;
`else
    g0 = can && s0 && (!s1 || m_last);
`endif
    g1 = can && s1 && !g0;
    chk("req0_ready", rdy0, g0);
    chk("req1_ready", rdy1, g1);
    chk("rsp0_valid", rsp0, e_r0);
    chk("rsp1_valid", rsp1, e_r1);
    if (m_known && !rst_i) begin
      chk("inflight", inflight, m_infl);
      chk("idle", idle, (m_infl == 0) && !g0 && !g1);
      chk("mul_A", mul_A, m_A);
      chk("mul_B", mul_B, m_B);
    end
    if (rsp0) n_rs0++;
    if (rsp1) n_rs1++;
    if (rst_i) begin
      sb.delete(); m_infl = 0; m_last = 1'b1; m_A = '0; m_B = '0; m_known = 1'b1;
    end else begin
      if (due) begin void'(sb.pop_front()); m_infl--; end
      if (g0 || g1) begin
        sb.push_back('{due: cyc + LAT, id: g1});
        m_infl++;
        m_last = g1;
        m_A = g0 ? ia0 : ia1;
        m_B = g0 ? ib0 : ib1;
        if (g0) n_gr0++; else n_gr1++;
      end
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  logic [AW-1:0] ones_a, ra0, ra1;
  logic [BW-1:0] twos_b, rb0, rb1;
  logic [7:0] e2_rdy = 8'b01100011;   // bit i = cycle i
  logic [7:0] e2_rsp = 8'b00110000;
  logic [1:0] e2_inf [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2};

  initial begin
    for (int e = 0; e < NE; e++) begin
      ones_a[e*AL +: AL] = AL'(1);
      twos_b[e*BL +: BL] = BL'(2);
    end

    // reset, then single req0 transaction with A=1s, B=2s
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    idle_cycles(1);
    step(1'b0, 1'b1, 1'b0, ones_a, '0, twos_b, '0);
    idle_cycles(6);

    // sustained contention: alternating grants (or req0-only with fixed prio)
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, rnd_a(), rnd_a(), rnd_b(), rnd_b());
    idle_cycles(6);

    // reset two cycles after a grant discards the outstanding response
    step(1'b0, 1'b0, 1'b1, rnd_a(), rnd_a(), rnd_b(), rnd_b());
    idle_cycles(1);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    idle_cycles(6);

    // random traffic, then drain and compare per-requester totals
    n_gr0 = 0; n_gr1 = 0; n_rs0 = 0; n_rs1 = 0;
    for (int i = 0; i < 10000; i++) begin
      ra0 = rnd_a(); ra1 = rnd_a(); rb0 = rnd_b(); rb1 = rnd_b();
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra0, ra1, rb0, rb1);
    end
    idle_cycles(LAT + 2);
    chk("sb_empty", sb.size(), 0);
    chk("rsp0_count", n_rs0, n_gr0);
    chk("rsp1_count", n_rs1, n_gr1);
    chk("drain_idle", idle, 1);

    // credit limit on the MAX_INFLIGHT=2 instance with req0 held valid
    reset = 1'b1;
    @(negedge clk); reset2 = 1'b1;
    @(negedge clk); reset2 = 1'b0; d2_v0 = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("d2_ready", d2_rdy0, e2_rdy[i]);
      chk("d2_rsp", d2_rsp0, e2_rsp[i]);
      chk("d2_inflight", d2_infl, e2_inf[i]);
      @(negedge clk); #1;
    end
    d2_v0 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
